serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 113 +++++++++++
 tb/tb_serial_adder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: captures two WIDTH-bit operands plus carry-in, adds them
// LSB-first one bit per clock, then holds the result under a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for an operand set, in_ready high
// RUN   | one full-add per cycle, shifting operands and partial sum right
// DONE  | result presented on sum/cout with out_valid high until taken
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             ha_s;
    logic             ha_c;
    logic             bit_s;
    logic             bit_c;
    logic [WIDTH-1:0] sum_next;

    // Two half-add cells form the full adder; the new sum bit enters at the MSB.
    always_comb begin
        ha_s               = a_sh[0] ^ b_sh[0];
        ha_c               = a_sh[0] & b_sh[0];
        bit_s              = ha_s ^ carry;
        bit_c              = ha_c | (carry & ha_s);
        sum_next           = sum_sh >> 1;
        sum_next[WIDTH-1]  = bit_s;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        carry    <= cin;
                        sum_sh   <= '0;
                        cnt      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= sum_next;
                    carry  <= bit_c;
                    cnt    <= cnt + CW'(1);
                    // Output registers load only on the last bit so they keep
                    // the previous result while a new add is in flight.
                    if (cnt == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        sum       <= sum_next;
                        cout      <= bit_c;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: an 8-bit and a 1-bit instance share clock
// and reset; stimulus queues expected results, negedge monitors pop and compare.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rstn;

    logic       iv8, ir8, cin8, ov8, or8, cout8, busy8;
    logic [7:0] a8, b8, s8;
    logic       iv1, ir1, cin1, ov1, or1, cout1, busy1;
    logic [0:0] a1, b1, s1;

    typedef struct {
        logic [7:0] s;
        logic       c;
    } exp_t;

    exp_t q8[$];
    exp_t q1[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int acc8, acc1;
    bit lat8 = 1'b0;
    bit lat1 = 1'b0;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rstn(rstn), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .cin(cin8), .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(cout8),
        .busy(busy8)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .cin(cin1), .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(cout1),
        .busy(busy1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            lat8 = 1'b0;
        end else begin
            if (iv8 && ir8) begin
                acc8 = cyc + 1;
                lat8 = 1'b1;
            end
            if (ov8 && lat8) begin
                chk("latency8", cyc - acc8 + 1, 9);
                lat8 = 1'b0;
            end
            if (ov8 && or8) begin
                if (q8.size() == 0) begin
                    chk("unexpected_out8", 0, 1);
                end else begin
                    e = q8.pop_front();
                    chk("sum8", {24'd0, s8}, {24'd0, e.s});
                    chk("cout8", {31'd0, cout8}, {31'd0, e.c});
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            lat1 = 1'b0;
        end else begin
            if (iv1 && ir1) begin
                acc1 = cyc + 1;
                lat1 = 1'b1;
            end
            if (ov1 && lat1) begin
                chk("latency1", cyc - acc1 + 1, 2);
                lat1 = 1'b0;
            end
            if (ov1 && or1) begin
                if (q1.size() == 0) begin
                    chk("unexpected_out1", 0, 1);
                end else begin
                    e = q1.pop_front();
                    chk("sum1", {31'd0, s1}, {31'd0, e.s[0]});
                    chk("cout1", {31'd0, cout1}, {31'd0, e.c});
                end
            end
        end
    end

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input bit push, input logic [7:0] es, input logic ec);
        int n = 0;
        while (!ir8 && n < 60) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 60) chk("ready8_timeout", {31'd0, ir8}, 1);
        a8 = a; b8 = b; cin8 = c; iv8 = 1'b1;
        if (push) q8.push_back('{es, ec});
        @(posedge clk); #1;
        iv8 = 1'b0;
    endtask

    task automatic issue1(input logic a, input logic b, input logic c,
                          input logic es, input logic ec);
        int n = 0;
        while (!ir1 && n < 60) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 60) chk("ready1_timeout", {31'd0, ir1}, 1);
        a1 = a; b1 = b; cin1 = c; iv1 = 1'b1;
        q1.push_back('{{7'd0, es}, ec});
        @(posedge clk); #1;
        iv1 = 1'b0;
    endtask

    task automatic wait_idle8();
        int n = 0;
        while (!ir8 && n < 60) begin
            @(posedge clk); #1; n++;
        end
        chk("idle8", {31'd0, ir8}, 1);
    endtask

    task automatic wait_valid8();
        int n = 0;
        while (!ov8 && n < 60) begin
            @(posedge clk); #1; n++;
        end
        chk("valid8_seen", {31'd0, ov8}, 1);
    endtask

    logic [7:0] va [7] = '{8'd3, 8'd255, 8'd255, 8'd0, 8'hA5, 8'd100, 8'd128};
    logic [7:0] vb [7] = '{8'd5, 8'd1,   8'd255, 8'd0, 8'h5A, 8'd200, 8'd128};
    logic       vc [7] = '{1'b0, 1'b0,   1'b1,   1'b1, 1'b0,  1'b0,   1'b1};
    logic [7:0] vs [7] = '{8'd8, 8'd0,   8'd255, 8'd1, 8'hFF, 8'd44,  8'd1};
    logic       vo [7] = '{1'b0, 1'b1,   1'b1,   1'b0, 1'b0,  1'b1,   1'b1};

    logic w1a [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic w1b [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic w1c [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic w1s [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic w1o [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        int hits;
        rstn = 1'b0;
        iv8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; or8 = 1'b1;
        iv1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; or1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, ir8}, 1);
        chk("rst_out_valid", {31'd0, ov8}, 0);
        chk("rst_busy", {31'd0, busy8}, 0);
        chk("rst_sum", {24'd0, s8}, 0);
        chk("rst_cout", {31'd0, cout8}, 0);
        rstn = 1'b1;

        // First operation is offered right after release: accepted on the first edge.
        for (int i = 0; i < 7; i++) begin
            issue8(va[i], vb[i], vc[i], 1'b1, vs[i], vo[i]);
            if (i == 0) begin
                chk("busy_in_run", {31'd0, busy8}, 1);
                chk("in_ready_in_run", {31'd0, ir8}, 0);
            end
            wait_idle8();
        end

        // Backpressure in DONE, with a stray in_valid that must be ignored.
        or8 = 1'b0;
        issue8(8'h12, 8'h34, 1'b1, 1'b1, 8'h47, 1'b0);
        wait_valid8();
        a8 = 8'hFF; b8 = 8'hFF; iv8 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_out_valid", {31'd0, ov8}, 1);
            chk("bp_sum", {24'd0, s8}, 32'h47);
            chk("bp_cout", {31'd0, cout8}, 0);
            chk("bp_in_ready", {31'd0, ir8}, 0);
            @(posedge clk); #1;
        end
        iv8 = 1'b0;
        or8 = 1'b1;
        @(posedge clk); #1;
        chk("xfer_out_valid", {31'd0, ov8}, 0);
        chk("xfer_in_ready", {31'd0, ir8}, 1);
        chk("xfer_busy", {31'd0, busy8}, 0);

        // Operands changed and in_valid pulsed mid-RUN.
        issue8(8'd10, 8'd20, 1'b0, 1'b1, 8'd30, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; iv8 = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        iv8 = 1'b0;
        chk("run_busy", {31'd0, busy8}, 1);
        wait_idle8();
        hits = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (ov8 || busy8) hits++;
        end
        chk("no_second_op", hits, 0);

        // Asynchronous reset three cycles into RUN discards the operation.
        issue8(8'd7, 8'd9, 1'b0, 1'b0, 8'd0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_in_ready", {31'd0, ir8}, 1);
        chk("arst_out_valid", {31'd0, ov8}, 0);
        chk("arst_busy", {31'd0, busy8}, 0);
        chk("arst_sum", {24'd0, s8}, 0);
        chk("arst_cout", {31'd0, cout8}, 0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        hits = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (ov8) hits++;
        end
        chk("no_valid_after_rst", hits, 0);
        issue8(8'd1, 8'd1, 1'b0, 1'b1, 8'd2, 1'b0);
        wait_idle8();

        // Single-bit build.
        for (int i = 0; i < 5; i++) begin
            issue1(w1a[i], w1b[i], w1c[i], w1s[i], w1o[i]);
            repeat (3) begin @(posedge clk); #1; end
        end

        repeat (4) begin @(posedge clk); #1; end
        chk("q8_drained", q8.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
